// File: rtl/byte_serial_subtractor_pkg.sv
// Shared definitions for the byte-serial subtractor: FSM states and width defaults.
package byte_serial_subtractor_pkg;

    localparam int DATA_W_DEF     = 32;
    localparam int SLICE_W_DEF    = 8;
    localparam int NUM_SLICES_DEF = DATA_W_DEF / SLICE_W_DEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/byte_serial_subtractor_sub_slice.sv
// One SLICE_W-bit combinational adder slice with carry in/out.
module sub_slice #(
    parameter int SLICE_W = 8
) (
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, cin};

endmodule

// File: rtl/byte_serial_subtractor.sv
// Multi-cycle subtractor: i_a - i_b, one SLICE_W-bit slice per clock, borrow kept in a register.
// Optional signed overflow output o_overflow enabled by defining SUB_OVERFLOW_EN.
module byte_serial_subtractor
    import byte_serial_subtractor_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int SLICE_W = SLICE_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_diff,
    output logic              o_borrow
`ifdef SUB_OVERFLOW_EN
    ,
    output logic              o_overflow
`endif
);

    localparam int NUM_SLICES = DATA_W / SLICE_W;
    localparam int CNT_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam int IDX_W      = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    if ((SLICE_W < 1) || ((DATA_W % SLICE_W) != 0)) begin : g_bad_width
        $error("DATA_W must be a positive multiple of SLICE_W");
    end

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  a_q, b_q, diff_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               carry_q;
    logic               borrow_q;
    logic [IDX_W-1:0]   slice_lo;
    logic               last_slice;
    logic [SLICE_W-1:0] slice_a, slice_nb, slice_r;
    logic               slice_c;

    always_comb begin
        slice_lo   = IDX_W'(int'(cnt_q) * SLICE_W);
        last_slice = (cnt_q == CNT_W'(NUM_SLICES - 1));
        slice_a    = a_q[slice_lo +: SLICE_W];
        slice_nb   = ~b_q[slice_lo +: SLICE_W];
    end

    // a - b computed as a + ~b + 1; the +1 enters as the initial carry.
    sub_slice #(.SLICE_W(SLICE_W)) u_slice (
        .a    (slice_a),
        .b    (slice_nb),
        .cin  (carry_q),
        .sum  (slice_r),
        .cout (slice_c)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_valid)    state_d = CALC;
            CALC:    if (last_slice) state_d = DONE;
            DONE:    if (i_ready)    state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

`ifdef SUB_OVERFLOW_EN
    logic overflow_q;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
`ifdef SUB_OVERFLOW_EN
            overflow_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: if (i_valid) begin
                    a_q     <= i_a;
                    b_q     <= i_b;
                    carry_q <= 1'b1;
                    cnt_q   <= '0;
                end
                CALC: begin
                    diff_q[slice_lo +: SLICE_W] <= slice_r;
                    carry_q <= slice_c;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (last_slice) begin
                        borrow_q <= ~slice_c;
`ifdef SUB_OVERFLOW_EN
                        overflow_q <= (a_q[DATA_W-1] != b_q[DATA_W-1]) &&
                                      (slice_r[SLICE_W-1] != a_q[DATA_W-1]);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_ready  = (state_q == IDLE);
    assign o_valid  = (state_q == DONE);
    assign o_diff   = diff_q;
    assign o_borrow = borrow_q;
`ifdef SUB_OVERFLOW_EN
    assign o_overflow = overflow_q;
`endif

endmodule

// File: tb/tb_byte_serial_subtractor.sv
// Directed self-checking bench for byte_serial_subtractor (SUB_OVERFLOW_EN adds overflow vectors).
module tb_byte_serial_subtractor;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [31:0] i_a = '0;
    logic [31:0] i_b = '0;
    logic        o_valid;
    logic        i_ready = 1'b1;
    logic [31:0] o_diff;
    logic        o_borrow;
`ifdef SUB_OVERFLOW_EN
    logic        o_overflow;
`endif

    int total = 0;
    int bad   = 0;
    int lat;

    always #5 i_clk = ~i_clk;

    byte_serial_subtractor #(.DATA_W(32), .SLICE_W(8)) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_a      (i_a),
        .i_b      (i_b),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_diff   (o_diff),
        .o_borrow (o_borrow)
`ifdef SUB_OVERFLOW_EN
        ,
        .o_overflow (o_overflow)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present operands for one edge; returns #1 after the accepting edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        i_a = a;
        i_b = b;
        i_valid = 1'b1;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        i_a = $urandom;
        i_b = $urandom;
    endtask

    // Counts edges after acceptance until o_valid is seen, bounded.
    task automatic wait_valid(output int n);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge i_clk);
            #1;
            n++;
            if (o_valid) break;
        end
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_ready",  32'(o_ready),  32'd1);
        chk("rst_valid",  32'(o_valid),  32'd0);
        chk("rst_diff",   o_diff,        32'h0);
        chk("rst_borrow", 32'(o_borrow), 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // 5 - 3
        issue(32'd5, 32'd3);
        chk("calc_ready", 32'(o_ready), 32'd0);
        wait_valid(lat);
        chk("lat_5_3",    32'(lat),      32'd4);
        chk("diff_5_3",   o_diff,        32'h00000002);
        chk("borrow_5_3", 32'(o_borrow), 32'd0);
`ifdef SUB_OVERFLOW_EN
        chk("ovf_5_3",    32'(o_overflow), 32'd0);
`endif
        @(posedge i_clk);
        #1;
        chk("ready_after_5_3", 32'(o_ready), 32'd1);
        chk("valid_after_5_3", 32'(o_valid), 32'd0);

        // 3 - 5 wraps
        issue(32'd3, 32'd5);
        wait_valid(lat);
        chk("lat_3_5",    32'(lat),      32'd4);
        chk("diff_3_5",   o_diff,        32'hFFFFFFFE);
        chk("borrow_3_5", 32'(o_borrow), 32'd1);
        @(posedge i_clk);
        #1;

        // borrow across the first slice boundary
        issue(32'h00000100, 32'h00000001);
        wait_valid(lat);
        chk("diff_x100",   o_diff,        32'h000000FF);
        chk("borrow_x100", 32'(o_borrow), 32'd0);
        @(posedge i_clk);
        #1;

`ifdef SUB_OVERFLOW_EN
        issue(32'h80000000, 32'h00000001);
        wait_valid(lat);
        chk("diff_ovf",   o_diff,          32'h7FFFFFFF);
        chk("ovf_ovf",    32'(o_overflow), 32'd1);
        chk("borrow_ovf", 32'(o_borrow),   32'd0);
        @(posedge i_clk);
        #1;
`endif

        // Backpressure with ignored i_valid pulses
        i_ready = 1'b0;
        issue(32'hDEADBEEF, 32'h0000BEEF);
        i_valid = 1'b1;
        i_a = 32'h11111111;
        i_b = 32'h22222222;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        wait_valid(lat);
        chk("lat_bp", 32'(lat), 32'd3);
        for (int i = 0; i < 3; i++) begin
            i_valid = 1'b1;
            @(posedge i_clk);
            #1;
            chk("bp_valid",  32'(o_valid),  32'd1);
            chk("bp_ready",  32'(o_ready),  32'd0);
            chk("bp_diff",   o_diff,        32'hDEAD0000);
            chk("bp_borrow", 32'(o_borrow), 32'd0);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        chk("bp_ready_after", 32'(o_ready), 32'd1);
        chk("bp_valid_after", 32'(o_valid), 32'd0);

        // Reset during slice 2
        issue(32'h12345678, 32'h00000001);
        @(posedge i_clk);
        #1;
        @(posedge i_clk);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("mr_ready",  32'(o_ready),  32'd1);
        chk("mr_valid",  32'(o_valid),  32'd0);
        chk("mr_diff",   o_diff,        32'h0);
        chk("mr_borrow", 32'(o_borrow), 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(posedge i_clk);
            #1;
            chk("mr_hold_valid", 32'(o_valid), 32'd0);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        issue(32'h0, 32'h0);
        wait_valid(lat);
        chk("lat_zero",    32'(lat),      32'd4);
        chk("diff_zero",   o_diff,        32'h0);
        chk("borrow_zero", 32'(o_borrow), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/byte_serial_subtractor.md
Name: byte_serial_subtractor

Overview:
- Multi-cycle 32-bit subtractor: o_diff = i_a - i_b, processed one SLICE_W-bit slice per clock, borrow rippled through a register between slices.
- Inverse operation of the team's 32-bit adder datapath; serves area-constrained paths where single-cycle subtraction is unnecessary.
- Valid/ready handshake on both sides; one operation in flight.

Parameters:
- DATA_W, 32, operand/result width; must be a multiple of SLICE_W (elaboration error otherwise).
- SLICE_W, 8, bits processed per cycle; NUM_SLICES = DATA_W/SLICE_W (4 by default).

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_valid  input  1  upstream operands valid.
- o_ready  output  1  block can accept operands (IDLE only).
- i_a  input  DATA_W  minuend.
- i_b  input  DATA_W  subtrahend.
- o_valid  output  1  result valid; held until consumed.
- i_ready  input  1  downstream accepts result.
- o_diff  output  DATA_W  i_a - i_b modulo 2^DATA_W.
- o_borrow  output  1  1 when unsigned i_a < i_b.

Behaviour:
- Reset (async assert, sync release): state=IDLE, o_ready=1, o_valid=0, o_diff=0, o_borrow=0, slice counter=0, operand registers=0.
- States: IDLE -> CALC -> DONE -> IDLE.
- IDLE: o_ready=1. On i_valid&&o_ready at edge T, latch i_a and i_b, set carry register=1 (two's-complement +1), counter=0, go to CALC.
- CALC: o_ready=0. At each edge, slice k = counter: {c, r} = a[k] + ~b[k] + carry; write r to result slice k; carry<=c; counter++. After slice NUM_SLICES-1 (edge T+NUM_SLICES), go to DONE and set o_borrow = ~final carry.
- Latency: o_valid goes high in the cycle after edge T+NUM_SLICES (4 cycles after accept at default). Throughput: one operation per NUM_SLICES+2 cycles minimum.
- DONE: o_valid=1; o_diff and o_borrow are stable while o_valid=1. On i_valid-independent i_ready=1, go to IDLE at that edge (o_valid drops, o_ready rises next cycle). i_ready low holds DONE indefinitely.
- i_valid is ignored outside IDLE; i_a and i_b may change freely after acceptance.
- o_diff contents are undefined during CALC and shown only in DONE (the implementation may expose partial results; the bench checks only while o_valid=1).
- Counter wrap: the counter resets to 0 on entry to CALC and never wraps within an operation.
- Reset mid-operation: aborts immediately; no o_valid is produced and the operation is lost.
- i_a == i_b: o_diff=0, o_borrow=0.

Optional Feature:
- Macro SUB_OVERFLOW_EN.
- Defined: adds output port o_overflow (1 bit), reset 0, valid with o_valid. It is set when signed subtraction overflows: sign(a) != sign(b) and sign(diff) != sign(a). It is computed at the final slice.
- Undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package holds the state enum (IDLE, CALC, DONE), DATA_W/SLICE_W defaults, and the derived NUM_SLICES constant.
- One sub-module: sub_slice. It is a SLICE_W-bit combinational adder with carry-in and carry-out, and the top feeds it the inverted b slice. The top holds the FSM, counter, operand/result registers, and carry register.

Test Plan:
- i_a=5, i_b=3, i_ready=1 -> o_valid 4 cycles after accept; o_diff=0x00000002, o_borrow=0.
- i_a=3, i_b=5 -> o_diff=0xFFFFFFFE, o_borrow=1.
- i_a=0x00000100, i_b=0x00000001 -> o_diff=0x000000FF, o_borrow=0; checks the borrow crossing the slice boundary. With SUB_OVERFLOW_EN, also i_a=0x80000000, i_b=1 -> o_diff=0x7FFFFFFF, o_overflow=1, o_borrow=0.
- Backpressure: i_a=0xDEADBEEF, i_b=0x0000BEEF, i_ready held low 3 cycles in DONE -> o_valid and o_diff=0xDEAD0000 stable; i_valid pulses during CALC/DONE are ignored; o_ready=1 one cycle after the i_ready handshake.
- i_rst_n asserted during CALC slice 2 -> all outputs return to reset values asynchronously and o_valid never rises. A new op after release, i_a=0, i_b=0, gives o_diff=0, o_borrow=0.
